// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uArtTx byte transmitter among NUM_REQ byte sources.
// Define UART_ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index-wins priority.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = 87,
  parameter int GAP_CYCLES   = 2,
  parameter int FRAME_CYCLES = 10*CLKS_PER_BIT+2,
  localparam int OW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clkTx,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  output logic                 busy,
  output logic [OW-1:0]        owner
);

  localparam int CNT_W = $clog2(FRAME_CYCLES+GAP_CYCLES+1);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(FRAME_CYCLES+GAP_CYCLES-1);

  // The frame must at least cover start, 8 data and stop bits of the transmitter.
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("uart_tx_arbiter: NUM_REQ must be within 2..8");
  end
  if (FRAME_CYCLES < 10*CLKS_PER_BIT) begin : g_bad_frame
    $error("uart_tx_arbiter: FRAME_CYCLES shorter than one serial frame");
  end

  typedef enum logic [1:0] {
    ST_FLUSH,
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 tx_start_q, tx_start_d;
  logic [OW-1:0]        owner_q, owner_d;

  logic                 found;
  int                   win;

  // Winner search: first set request starting just after the previous owner, wrapping.
  always_comb begin
    int base;
    int idx;
    found = 1'b0;
    win   = 0;
`ifdef UART_ARB_FIXED_PRIO_EN
    base  = 0;
`else
    base  = int'(owner_q) + 1;
    if (base >= NUM_REQ) base = 0;
`endif
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = base + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ack_d      = '0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    owner_d    = owner_q;
    unique case (state_q)
      ST_FLUSH: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_IDLE: begin
        if (found) begin
          tx_data_d  = req_data[win*8 +: 8];
          owner_d    = OW'(win);
          ack_d[win] = 1'b1;
          state_d    = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        tx_start_d = 1'b1;
        cnt_d      = RELOAD;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = ST_FLUSH;
    endcase
  end

  // Reset flushes a full frame plus gap so a frame already handed to the
  // un-resettable transmitter can finish before the next launch.
  always_ff @(posedge clkTx) begin
    if (rst) begin
      state_q    <= ST_FLUSH;
      cnt_q      <= RELOAD;
      ack_q      <= '0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      owner_q    <= OW'(NUM_REQ-1);
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      owner_q    <= owner_d;
    end
  end

  assign ack      = ack_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign owner    = owner_q;
  assign busy     = (state_q != ST_IDLE);

endmodule
